data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Multi-cycle data-memory responder that services load/store requests from the CPU
//  over a valid/ready handshake. Word and byte accesses; little-endian byte lanes.
//  Used where data memory has real access latency, in place of a zero-latency array.
//  Sits between the CPU memory stage (initiator) and the storage array it owns.
// PARAMETERS
//  ADDR_W      18    byte-address width of req_addr
//  DEPTH_WORDS 1024  number of 32-bit words stored; valid byte addresses 0..4*DEPTH_WORDS-1
//  LATENCY     2     cycles from request accept to resp_valid; legal range 1..15
// PORTS
//  clock       in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  req_valid   in   1       initiator presents a request
//  req_ready   out  1       responder can accept; high only in IDLE
//  req_write   in   1       1 = store, 0 = load
//  req_byte    in   1       1 = byte access, 0 = word access
//  req_addr    in   ADDR_W  byte address
//  req_wdata   in   32      store data; byte store uses bits [7:0]
//  resp_valid  out  1       response available; held until resp_ready
//  resp_ready  in   1       initiator accepts response
//  resp_rdata  out  32      load data; 0 for stores and errors
//  resp_err    out  1       misaligned word access or out-of-range address
// BEHAVIOUR
//  - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
//    Array contents are not reset. Reset mid-operation drops the pending request; no
//    write commits.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: accept on req_valid & req_ready; latch write/byte/addr/wdata;
//      counter <= LATENCY-1; go WAIT.
//    WAIT: if counter==0, perform access and go RESP; else decrement counter.
//    RESP: resp_valid=1. On resp_ready, go IDLE and clear resp_valid.
//  - Latency: request accepted at edge N -> resp_valid high after edge N+LATENCY.
//    With resp_ready held high, back-to-back throughput is one access per LATENCY+2 cycles.
//  - Request inputs are ignored outside IDLE. Response fields stay stable while
//    resp_valid=1 and resp_ready=0.
//  - Word access: addr[1:0] must be 00, otherwise resp_err=1 with no array update.
//  - Byte store: writes wdata[7:0] into lane addr[1:0] of word addr[ADDR_W-1:2].
//    The other three lanes are unchanged.
//  - Byte load: resp_rdata = sign-extended byte from lane addr[1:0].
//  - Address with word index >= DEPTH_WORDS: resp_err=1, no write, resp_rdata=0.
//  - Store response: resp_rdata=0, resp_err=0 on success.
//  - Write commits exactly once, on the WAIT->RESP edge.
//    A read issued after a store's response observes the stored data.
// CONFIGURATION
//  DMEM_STATS_EN defined:
//    - Extra outputs rd_count[15:0] and wr_count[15:0], reset to 0.
//    - On each WAIT->RESP edge, the matching counter increments for successful
//      (non-error) loads/stores respectively; it saturates at 16'hFFFF.
//  DMEM_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Word store, LATENCY=2: addr 0x10, wdata 0xDEADBEEF, accept at edge N
//     -> resp_valid at N+2, resp_err=0. Load 0x10 -> resp_rdata=0xDEADBEEF.
//  2. Byte stores 0x11,0x22,0x33,0x84 to addr 0x20..0x23 -> word load 0x20
//     returns 0x84332211; byte load 0x23 returns 0xFFFFFF84.
//  3. Word load at addr 0x06 -> resp_err=1, resp_rdata=0.
//     Word store at 0x1002 (DEPTH 1024) -> resp_err=1, array unchanged.
//  4. Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid/rdata
//     held; req_ready=0; new req_valid ignored until handshake completes.
//  5. Assert reset_n low in WAIT of a store to 0x40 (old 0x0) -> outputs return to
//     reset values; subsequent load 0x40 returns 0x00000000.
//  6. DMEM_STATS_EN: 3 good loads, 2 good stores, 1 error -> rd_count=3, wr_count=2.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data-memory responder. It accepts one load/store at a time from the
//   CPU memory stage over a valid/ready handshake, waits LATENCY cycles, performs
//   the access on its own storage array, and then holds the response until the
//   initiator takes it. Word and byte accesses are supported with little-endian
//   byte lanes. Byte loads return the selected byte sign-extended.
//
//   Parameters
//     ADDR_W      byte-address width of req_addr
//     DEPTH_WORDS number of 32-bit words stored
//     LATENCY     cycles from request accept to resp_valid (1..15)
//
//   Ports
//     clock       rising-edge clock
//     reset_n     asynchronous active-low reset
//     req_valid   initiator presents a request
//     req_ready   responder can accept; high only while idle
//     req_write   1 = store, 0 = load
//     req_byte    1 = byte access, 0 = word access
//     req_addr    byte address
//     req_wdata   store data; byte store uses bits [7:0]
//     resp_valid  response available; held until resp_ready
//     resp_ready  initiator accepts response
//     resp_rdata  load data; 0 for stores and errors
//     resp_err    misaligned word access or out-of-range address
//
//   Optional feature (macro DMEM_STATS_EN)
//     rd_count / wr_count: saturating 16-bit counts of successful loads/stores.
//     Without the macro these ports and counters do not exist.

module data_mem_responder #(
  parameter int ADDR_W      = 18,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // The counter is loaded with LATENCY-1 so that the access happens on the
  // LATENCY-th edge after the accept edge.
  localparam logic [3:0]        CNT_INIT  = 4'(LATENCY - 1);
  localparam logic [ADDR_W-2:0] DEPTH_LIM = (ADDR_W - 1)'(DEPTH_WORDS);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q, write_d;
  logic              byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef DMEM_STATS_EN
  logic [15:0]       rd_count_q, rd_count_d;
  logic [15:0]       wr_count_q, wr_count_d;
`endif

  logic [31:0]       mem [DEPTH_WORDS];

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic              acc_err;
  logic              access_now;
  logic              mem_we;
  logic [31:0]       old_word;
  logic [31:0]       new_word;
  logic [7:0]        sel_byte;

  // Decode of the latched request: error detection, lane selection and the
  // read-modify-write word for byte stores.
  always_comb begin
    word_idx   = addr_q[ADDR_W-1:2];
    mem_idx    = addr_q[IDX_W+1:2];
    lane       = addr_q[1:0];
    acc_err    = (!byte_q && (lane != 2'b00)) || ({1'b0, word_idx} >= DEPTH_LIM);
    access_now = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    // Out-of-range stores must not alias onto a real word, so the error gates the write.
    mem_we     = access_now && write_q && !acc_err;
    old_word   = mem[mem_idx];
    sel_byte   = old_word[{lane, 3'b000} +: 8];
    new_word   = old_word;
    if (byte_q) begin
      new_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
    end else begin
      new_word = wdata_q;
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP -> IDLE sequence.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
`ifdef DMEM_STATS_EN
    rd_count_d   = rd_count_q;
    wr_count_d   = wr_count_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          err_d        = acc_err;
          if (acc_err || write_q) begin
            rdata_d = 32'd0;
          end else if (byte_q) begin
            rdata_d = {{24{sel_byte[7]}}, sel_byte};
          end else begin
            rdata_d = old_word;
          end
`ifdef DMEM_STATS_EN
          if (!acc_err && !write_q && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
          end
          if (!acc_err && write_q && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          rdata_d      = 32'd0;
          err_d        = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
`ifdef DMEM_STATS_EN
      rd_count_q   <= 16'd0;
      wr_count_q   <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      byte_q       <= byte_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
`ifdef DMEM_STATS_EN
      rd_count_q   <= rd_count_d;
      wr_count_q   <= wr_count_d;
`endif
    end
  end

  // Storage array has no reset; a reset during WAIT forces the state back to
  // IDLE asynchronously, so the pending write never commits.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_idx] <= new_word;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
`ifdef DMEM_STATS_EN
  assign rd_count   = rd_count_q;
  assign wr_count   = wr_count_q;
`endif

endmodule
